// File: rtl/char_match_pkg.sv
// char_match_pkg -- shared definitions for the character match engine.
//   GLYPH_W_DEFAULT : default glyph bitmap width (5 columns x 8 rows)
//   ASCII_UNKNOWN   : code reported when no template is close enough
//   cme_state_e     : match FSM states
//   dist_w()        : width needed to hold a Hamming distance 0..glyph_w
package char_match_pkg;

  localparam int unsigned GLYPH_W_DEFAULT = 40;
  localparam logic [7:0]  ASCII_UNKNOWN   = 8'h3F;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } cme_state_e;

  function automatic int unsigned dist_w(input int unsigned glyph_w);
    return $clog2(glyph_w + 1);
  endfunction

endpackage

// File: rtl/char_template_rom.sv
// char_template_rom -- combinational glyph template table.
//   idx     : template index (0-9 -> '0'-'9', 10-35 -> 'A'-'Z')
//   o_glyph : 5x8 bitmap, row 0 in the MSBs, leftmost pixel first;
//             row 7 is the blank descender row
//   o_ascii : ASCII code of the template
module char_template_rom
  import char_match_pkg::*;
#(
  parameter int unsigned GLYPH_W = GLYPH_W_DEFAULT,
  parameter int unsigned NUM_TPL = 36,
  parameter int unsigned IW      = 6
) (
  input  logic [IW-1:0]      idx,
  output logic [GLYPH_W-1:0] o_glyph,
  output logic [7:0]         o_ascii
);

  logic [39:0] font;
  logic [7:0]  idx8;

  always_comb begin
    idx8    = 8'(idx);
    font    = '0;
    o_ascii = ASCII_UNKNOWN;
    if (idx8 < 8'd10)      o_ascii = 8'h30 + idx8;
    else if (idx8 < 8'd36) o_ascii = 8'h37 + idx8;
    case (idx8)
      8'd0:  font = 40'b01110_10001_10011_10101_11001_10001_01110_00000;
      8'd1:  font = 40'b00100_01100_00100_00100_00100_00100_01110_00000;
      8'd2:  font = 40'b01110_10001_00001_00010_00100_01000_11111_00000;
      8'd3:  font = 40'b11111_00010_00100_00010_00001_10001_01110_00000;
      8'd4:  font = 40'b00010_00110_01010_10010_11111_00010_00010_00000;
      8'd5:  font = 40'b11111_10000_11110_00001_00001_10001_01110_00000;
      8'd6:  font = 40'b00110_01000_10000_11110_10001_10001_01110_00000;
      8'd7:  font = 40'b11111_00001_00010_00100_01000_01000_01000_00000;
      8'd8:  font = 40'b01110_10001_10001_01110_10001_10001_01110_00000;
      8'd9:  font = 40'b01110_10001_10001_01111_00001_00010_01100_00000;
      8'd10: font = 40'b01110_10001_10001_10001_11111_10001_10001_00000;
      8'd11: font = 40'b11110_10001_10001_11110_10001_10001_11110_00000;
      8'd12: font = 40'b01110_10001_10000_10000_10000_10001_01110_00000;
      8'd13: font = 40'b11100_10010_10001_10001_10001_10010_11100_00000;
      8'd14: font = 40'b11111_10000_10000_11110_10000_10000_11111_00000;
      8'd15: font = 40'b11111_10000_10000_11110_10000_10000_10000_00000;
      8'd16: font = 40'b01110_10001_10000_10111_10001_10001_01111_00000;
      8'd17: font = 40'b10001_10001_10001_11111_10001_10001_10001_00000;
      8'd18: font = 40'b01110_00100_00100_00100_00100_00100_01110_00000;
      8'd19: font = 40'b00111_00010_00010_00010_00010_10010_01100_00000;
      8'd20: font = 40'b10001_10010_10100_11000_10100_10010_10001_00000;
      8'd21: font = 40'b10000_10000_10000_10000_10000_10000_11111_00000;
      8'd22: font = 40'b10001_11011_10101_10101_10001_10001_10001_00000;
      8'd23: font = 40'b10001_10001_11001_10101_10011_10001_10001_00000;
      8'd24: font = 40'b01110_10001_10001_10001_10001_10001_01110_00000;
      8'd25: font = 40'b11110_10001_10001_11110_10000_10000_10000_00000;
      8'd26: font = 40'b01110_10001_10001_10001_10101_10010_01101_00000;
      8'd27: font = 40'b11110_10001_10001_11110_10100_10010_10001_00000;
      8'd28: font = 40'b01111_10000_10000_01110_00001_00001_11110_00000;
      8'd29: font = 40'b11111_00100_00100_00100_00100_00100_00100_00000;
      8'd30: font = 40'b10001_10001_10001_10001_10001_10001_01110_00000;
      8'd31: font = 40'b10001_10001_10001_10001_10001_01010_00100_00000;
      8'd32: font = 40'b10001_10001_10001_10101_10101_10101_01010_00000;
      8'd33: font = 40'b10001_10001_01010_00100_01010_10001_10001_00000;
      8'd34: font = 40'b10001_10001_01010_00100_00100_00100_00100_00000;
      8'd35: font = 40'b11111_00001_00010_00100_01000_10000_11111_00000;
      default: font = '0;
    endcase
    // Indices past the configured template count are treated as empty.
    if (32'(idx) >= NUM_TPL) begin
      font    = '0;
      o_ascii = ASCII_UNKNOWN;
    end
  end

  assign o_glyph = GLYPH_W'(font);

endmodule

// File: rtl/char_match_engine.sv
// char_match_engine -- nearest-template OCR for NUM_CH glyph channels.
//   pixelclk, reset_n : clock, async active-low reset
//   i_vsync           : frame sync; falling edge marks frame boundary
//   i_frame_cnt       : frame index; matching runs when == MATCH_FRAME
//   i_char            : NUM_CH glyphs, channel k at [k*GLYPH_W +: GLYPH_W]
//   o_char_result     : ASCII per channel (k at [k*8 +: 8]), '?' if no match
//   o_char_dist       : best Hamming distance per channel (k at [k*DW +: DW])
//   o_valid           : one-cycle pulse when results update
//   o_busy            : high while a scan is in progress
//   o_overrun         : sticky, set when a qualifying frame edge is dropped
module char_match_engine
  import char_match_pkg::*;
#(
  parameter int unsigned NUM_CH      = 8,
  parameter int unsigned GLYPH_W     = GLYPH_W_DEFAULT,
  parameter int unsigned NUM_TPL     = 36,
  parameter int unsigned MAX_DIST    = 6,
  parameter logic [2:0]  MATCH_FRAME = 3'd0,
  localparam int unsigned DW         = dist_w(GLYPH_W)
) (
  input  logic                        pixelclk,
  input  logic                        reset_n,
  input  logic                        i_vsync,
  input  logic [2:0]                  i_frame_cnt,
  input  logic [NUM_CH*GLYPH_W-1:0]   i_char,
  output logic [NUM_CH*8-1:0]         o_char_result,
  output logic [NUM_CH*DW-1:0]        o_char_dist,
  output logic                        o_valid,
  output logic                        o_busy,
  output logic                        o_overrun
);

  localparam int unsigned IW       = (NUM_TPL > 1) ? $clog2(NUM_TPL) : 1;
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_TPL - 1);
  localparam logic [DW-1:0] MAX_DIST_D = DW'(MAX_DIST);

  cme_state_e           state_q, state_d;
  logic                 vsync_q;
  logic [IW-1:0]        idx_q, idx_d;
  logic [GLYPH_W-1:0]   bank_q      [NUM_CH];
  logic [GLYPH_W-1:0]   bank_d      [NUM_CH];
  logic [DW-1:0]        best_dist_q [NUM_CH];
  logic [DW-1:0]        best_dist_d [NUM_CH];
  // The ASCII code of the best template is kept instead of its index,
  // so DONE needs no second ROM lookup.
  logic [7:0]           best_code_q [NUM_CH];
  logic [7:0]           best_code_d [NUM_CH];
  logic [NUM_CH*8-1:0]  result_q, result_d;
  logic [NUM_CH*DW-1:0] dist_q, dist_d;
  logic                 valid_q, valid_d;
  logic                 overrun_q, overrun_d;

  logic [GLYPH_W-1:0]   tpl_glyph;
  logic [7:0]           tpl_ascii;
  logic [DW-1:0]        ch_dist [NUM_CH];
  logic                 vsync_pos, edge_qual, frame_start;

  char_template_rom #(
    .GLYPH_W (GLYPH_W),
    .NUM_TPL (NUM_TPL),
    .IW      (IW)
  ) u_rom (
    .idx     (idx_q),
    .o_glyph (tpl_glyph),
    .o_ascii (tpl_ascii)
  );

  assign vsync_pos   = vsync_q & ~i_vsync;
  assign edge_qual   = vsync_pos & (i_frame_cnt == MATCH_FRAME);
  assign frame_start = edge_qual & (state_q == ST_IDLE);

  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      ch_dist[c] = '0;
      for (int unsigned b = 0; b < GLYPH_W; b++)
        ch_dist[c] = ch_dist[c] + DW'(bank_q[c][b] ^ tpl_glyph[b]);
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    bank_d      = bank_q;
    best_dist_d = best_dist_q;
    best_code_d = best_code_q;
    result_d    = result_q;
    dist_d      = dist_q;
    valid_d     = 1'b0;
    overrun_d   = overrun_q;

    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          for (int unsigned c = 0; c < NUM_CH; c++) begin
            bank_d[c]      = i_char[c*GLYPH_W +: GLYPH_W];
            best_dist_d[c] = '1;
          end
          idx_d   = '0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
          if (ch_dist[c] < best_dist_q[c]) begin
            best_dist_d[c] = ch_dist[c];
            best_code_d[c] = tpl_ascii;
          end
        end
        if (idx_q == LAST_IDX) begin
          // Results are registered on the edge into DONE so they are
          // visible in the same cycle as the o_valid pulse.
          for (int unsigned c = 0; c < NUM_CH; c++) begin
            result_d[c*8 +: 8]  = (best_dist_d[c] <= MAX_DIST_D) ?
                                  best_code_d[c] : ASCII_UNKNOWN;
            dist_d[c*DW +: DW]  = best_dist_d[c];
          end
          valid_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (edge_qual && (state_q != ST_IDLE)) overrun_d = 1'b1;
  end

  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      vsync_q   <= 1'b0;
      idx_q     <= '0;
      result_q  <= '0;
      dist_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        bank_q[c]      <= '0;
        best_dist_q[c] <= '0;
        best_code_q[c] <= '0;
      end
    end else begin
      state_q     <= state_d;
      vsync_q     <= i_vsync;
      idx_q       <= idx_d;
      bank_q      <= bank_d;
      best_dist_q <= best_dist_d;
      best_code_q <= best_code_d;
      result_q    <= result_d;
      dist_q      <= dist_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign o_char_result = result_q;
  assign o_char_dist   = dist_q;
  assign o_valid       = valid_q;
  assign o_busy        = (state_q != ST_IDLE);
  assign o_overrun     = overrun_q;

endmodule

// File: tb/tb_char_match_engine.sv
// tb_char_match_engine -- directed self-checking bench for char_match_engine.
module tb_char_match_engine;

  localparam int unsigned NUM_CH  = 8;
  localparam int unsigned GLYPH_W = 40;
  localparam int unsigned DW      = 6;

  localparam logic [39:0] G_0   = 40'b01110_10001_10011_10101_11001_10001_01110_00000;
  localparam logic [39:0] G_1   = 40'b00100_01100_00100_00100_00100_00100_01110_00000;
  localparam logic [39:0] G_2   = 40'b01110_10001_00001_00010_00100_01000_11111_00000;
  localparam logic [39:0] G_3   = 40'b11111_00010_00100_00010_00001_10001_01110_00000;
  localparam logic [39:0] G_A   = 40'b01110_10001_10001_10001_11111_10001_10001_00000;
  localparam logic [39:0] G_B   = 40'b11110_10001_10001_11110_10001_10001_11110_00000;
  localparam logic [39:0] G_C   = 40'b01110_10001_10000_10000_10000_10001_01110_00000;
  localparam logic [39:0] G_Z   = 40'b11111_00001_00010_00100_01000_10000_11111_00000;
  // Three pixels from '0' and three from '8'; every other template is farther.
  localparam logic [39:0] G_TIE = 40'b01110_10001_10011_11110_11001_10001_01110_00000;
  // Flip masks: blank-row pixels only (3), blank row plus two top corners (7).
  localparam logic [39:0] FLIP3 = 40'h00_0000_0007;
  localparam logic [39:0] FLIP7 = 40'h88_0000_001F;

  logic                        pixelclk = 1'b0;
  logic                        reset_n;
  logic                        i_vsync;
  logic [2:0]                  i_frame_cnt;
  logic [NUM_CH*GLYPH_W-1:0]   i_char;
  logic [NUM_CH*8-1:0]         o_char_result;
  logic [NUM_CH*DW-1:0]        o_char_dist;
  logic                        o_valid;
  logic                        o_busy;
  logic                        o_overrun;

  int checks   = 0;
  int failures = 0;

  char_match_engine #(
    .NUM_CH      (NUM_CH),
    .GLYPH_W     (GLYPH_W),
    .NUM_TPL     (36),
    .MAX_DIST    (6),
    .MATCH_FRAME (3'd0)
  ) dut (
    .pixelclk      (pixelclk),
    .reset_n       (reset_n),
    .i_vsync       (i_vsync),
    .i_frame_cnt   (i_frame_cnt),
    .i_char        (i_char),
    .o_char_result (o_char_result),
    .o_char_dist   (o_char_dist),
    .o_valid       (o_valid),
    .o_busy        (o_busy),
    .o_overrun     (o_overrun)
  );

  always #5 pixelclk = ~pixelclk;

  task automatic tick();
    @(posedge pixelclk);
    #1;
  endtask

  // One frame: falling vsync edge in cycle 0, i_char scrambled after capture,
  // optional second qualifying edge mid-scan. Observes 45 cycles.
  task automatic run_frame(input logic [2:0] fc, input bit second_fall,
                           output int valid_cycle, output int valid_count,
                           output int busy_bad, output int unstable);
    logic [NUM_CH*8-1:0] prev;
    valid_cycle = -1;
    valid_count = 0;
    busy_bad    = 0;
    unstable    = 0;
    i_vsync     = 1'b1;
    i_frame_cnt = fc;
    tick();
    prev    = o_char_result;
    i_vsync = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      tick();
      if (c == 1) i_char = ~i_char;
      if (c == 2) i_vsync = 1'b1;
      if (second_fall && c == 4) i_vsync = 1'b0;
      if (second_fall && c == 6) i_vsync = 1'b1;
      if (o_valid) begin
        valid_count++;
        if (valid_cycle < 0) valid_cycle = c;
      end
      if (o_busy !== (c <= 37)) busy_bad++;
      if (!o_valid && (o_char_result !== prev)) unstable++;
      prev = o_char_result;
    end
  endtask

  task automatic test_reset();
    int busy_seen;
    reset_n     = 1'b0;
    i_vsync     = 1'b0;
    i_frame_cnt = 3'd0;
    i_char      = '0;
    #2;
    checks++;
    if (o_char_result !== '0 || o_char_dist !== '0) begin
      failures++;
      $display("FAIL reset_data: result=%h dist=%h required 0/0", o_char_result, o_char_dist);
    end
    checks++;
    if ({o_valid, o_busy, o_overrun} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags: valid/busy/overrun=%b required 000", {o_valid, o_busy, o_overrun});
    end
    tick();
    tick();
    // Release with vsync already low: no registered high level, so no edge.
    reset_n   = 1'b1;
    busy_seen = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (o_busy) busy_seen++;
    end
    checks++;
    if (busy_seen != 0) begin
      failures++;
      $display("FAIL reset_release_edge: busy cycles=%0d required 0", busy_seen);
    end
    i_vsync = 1'b1;
    tick();
  endtask

  task automatic test_exact();
    int vc, vn, bb, us;
    i_char = {{7{G_0}}, G_A};
    run_frame(3'd0, 1'b0, vc, vn, bb, us);
    checks++;
    if (vc != 37 || vn != 1) begin
      failures++;
      $display("FAIL exact_latency: valid cycle=%0d pulses=%0d required 37/1", vc, vn);
    end
    checks++;
    if (bb != 0) begin
      failures++;
      $display("FAIL exact_busy: bad busy cycles=%0d required 0", bb);
    end
    checks++;
    if (o_char_result[7:0] !== 8'h41 || o_char_dist[5:0] !== 6'd0) begin
      failures++;
      $display("FAIL exact_ch0: result=%h dist=%0d required 41/0", o_char_result[7:0], o_char_dist[5:0]);
    end
    checks++;
    if (o_char_result[15:8] !== 8'h30 || o_char_dist[11:6] !== 6'd0) begin
      failures++;
      $display("FAIL exact_ch1: result=%h dist=%0d required 30/0", o_char_result[15:8], o_char_dist[11:6]);
    end
  endtask

  task automatic test_near();
    int vc, vn, bb, us;
    i_char = {{7{G_0}}, G_A ^ FLIP3};
    run_frame(3'd0, 1'b0, vc, vn, bb, us);
    checks++;
    if (o_char_result[7:0] !== 8'h41 || o_char_dist[5:0] !== 6'd3) begin
      failures++;
      $display("FAIL near3: result=%h dist=%0d required 41/3", o_char_result[7:0], o_char_dist[5:0]);
    end
    i_char = {{7{G_0}}, G_A ^ FLIP7};
    run_frame(3'd0, 1'b0, vc, vn, bb, us);
    checks++;
    if (o_char_result[7:0] !== 8'h3F || o_char_dist[5:0] !== 6'd7) begin
      failures++;
      $display("FAIL near7: result=%h dist=%0d required 3f/7", o_char_result[7:0], o_char_dist[5:0]);
    end
  endtask

  task automatic test_tie();
    int vc, vn, bb, us;
    i_char = {{7{G_1}}, G_TIE};
    run_frame(3'd0, 1'b0, vc, vn, bb, us);
    checks++;
    if (o_char_result[7:0] !== 8'h30 || o_char_dist[5:0] !== 6'd3) begin
      failures++;
      $display("FAIL tie: result=%h dist=%0d required 30/3", o_char_result[7:0], o_char_dist[5:0]);
    end
  endtask

  task automatic test_frame_gating();
    int busy_seen;
    busy_seen   = 0;
    i_vsync     = 1'b1;
    i_frame_cnt = 3'd2;
    tick();
    i_vsync = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 2) i_vsync = 1'b1;
      if (o_busy || o_valid) busy_seen++;
    end
    checks++;
    if (busy_seen != 0 || o_overrun !== 1'b0) begin
      failures++;
      $display("FAIL gating: busy/valid cycles=%0d overrun=%b required 0/0", busy_seen, o_overrun);
    end
    i_frame_cnt = 3'd0;
  endtask

  task automatic test_overrun();
    int vc, vn, bb, us;
    i_char = {{7{G_0}}, G_A};
    run_frame(3'd0, 1'b1, vc, vn, bb, us);
    checks++;
    if (o_overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_flag: overrun=%b required 1", o_overrun);
    end
    checks++;
    if (vc != 37 || vn != 1 || o_char_result[7:0] !== 8'h41) begin
      failures++;
      $display("FAIL overrun_scan: valid cycle=%0d pulses=%0d result=%h required 37/1/41",
               vc, vn, o_char_result[7:0]);
    end
  endtask

  task automatic test_reset_midscan();
    int stray;
    i_char      = {8{G_A}};
    i_vsync     = 1'b1;
    i_frame_cnt = 3'd0;
    tick();
    i_vsync = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 2) i_vsync = 1'b1;
    end
    checks++;
    if (o_busy !== 1'b1) begin
      failures++;
      $display("FAIL midscan_busy: busy=%b required 1", o_busy);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (o_char_result !== '0 || o_char_dist !== '0 ||
        {o_valid, o_busy, o_overrun} !== 3'b000) begin
      failures++;
      $display("FAIL midscan_reset: result=%h dist=%h flags=%b required 0/0/000",
               o_char_result, o_char_dist, {o_valid, o_busy, o_overrun});
    end
    tick();
    tick();
    reset_n = 1'b1;
    stray   = 0;
    for (int c = 0; c < 45; c++) begin
      tick();
      if (o_valid || o_busy) stray++;
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("FAIL midscan_abandon: valid/busy cycles=%0d required 0", stray);
    end
  endtask

  task automatic test_all_channels();
    int vc, vn, bb, us;
    i_char = {G_Z, G_C, G_B, G_A, G_3, G_2, G_1, G_0};
    run_frame(3'd0, 1'b0, vc, vn, bb, us);
    checks++;
    if (o_char_result !== 64'h5A43424133323130) begin
      failures++;
      $display("FAIL all_ch_result: got %h required 5a43424133323130", o_char_result);
    end
    checks++;
    if (o_char_dist !== 48'h0 || vc != 37) begin
      failures++;
      $display("FAIL all_ch_dist: dist=%h valid cycle=%0d required 0/37", o_char_dist, vc);
    end
  endtask

  task automatic test_back_to_back();
    int vc, vn, bb, us;
    i_char = {{7{G_0}}, G_B};
    run_frame(3'd0, 1'b0, vc, vn, bb, us);
    checks++;
    if (o_char_result[7:0] !== 8'h42 || us != 0) begin
      failures++;
      $display("FAIL b2b_first: result=%h unstable=%0d required 42/0", o_char_result[7:0], us);
    end
    i_char = {{7{G_0}}, G_TIE};
    run_frame(3'd0, 1'b0, vc, vn, bb, us);
    checks++;
    if (o_char_result[7:0] !== 8'h30 || o_char_dist[5:0] !== 6'd3 || vn != 1 || us != 0) begin
      failures++;
      $display("FAIL b2b_second: result=%h dist=%0d pulses=%0d unstable=%0d required 30/3/1/0",
               o_char_result[7:0], o_char_dist[5:0], vn, us);
    end
  endtask

  initial begin
    test_reset();
    test_exact();
    test_near();
    test_tie();
    test_frame_gating();
    test_overrun();
    test_reset_midscan();
    test_all_channels();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
